// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline boundary: valid/ready handshake, 2-entry skid buffer,
// stall (hold) and flush (bubble) semantics, saturating performance counters.
module if_id_skid_stage #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_plus4,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [PC_W-1:0]    main_pc4_q, main_pc4_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic            in_fire;
    logic            out_fire;
    logic [PC_W-1:0] in_pc_plus4;

    // Handshake outputs depend only on registered state.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_pc_plus4 = in_pc + PC_W'(4);

    assign out_pc       = out_valid ? main_pc_q    : '0;
    assign out_pc_plus4 = out_valid ? main_pc4_q   : '0;
    assign out_instr    = out_valid ? main_instr_q : NOP_INSTR;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_pc4_d   = main_pc4_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_pc_d    = in_pc;
                    main_pc4_d   = in_pc_plus4;
                    main_instr_d = in_instr;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_pc_d    = in_pc;
                    main_pc4_d   = in_pc_plus4;
                    main_instr_d = in_instr;
                end else if (in_fire) begin
                    skid_pc_d    = in_pc;
                    skid_pc4_d   = in_pc_plus4;
                    skid_instr_d = in_instr;
                    state_d      = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_pc_d    = skid_pc_q;
                    main_pc4_d   = skid_pc4_q;
                    main_instr_d = skid_instr_q;
                    state_d      = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Contents are left as-is on flush; the EMPTY state masks them.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_pc_q    <= '0;
            main_pc4_q   <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            skid_instr_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_pc4_q   <= main_pc4_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed scenarios plus random traffic, checked
// against a queue-based model of a 2-deep in-order buffer.
module tb_if_id_skid_stage;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
    localparam int VW = 1 + 1 + PC_W + PC_W + INSTR_W + CNT_W + CNT_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc = '0;
    logic [INSTR_W-1:0] in_instr = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc_plus4;
    logic [INSTR_W-1:0] out_instr;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t             mq[$];
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    if_id_skid_stage #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] act_vec();
        return {out_valid, in_ready, out_pc, out_pc_plus4, out_instr, stall_cnt, flush_cnt};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [PC_W-1:0] p4;
        if (mq.size() > 0) begin
            p4 = mq[0].pc + PC_W'(4);
            return {1'b1, mq.size() < 2, mq[0].pc, p4, mq[0].instr, m_stall, m_flush};
        end
        return {1'b0, 1'b1, {PC_W{1'b0}}, {PC_W{1'b0}}, NOP, m_stall, m_flush};
    endfunction

    // One clock: apply inputs, advance the model at the edge, return at negedge.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                        input logic ordy);
        bit ir;
        bit ov;
        reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
        ir = (mq.size() < 2);
        ov = (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_stall = '0;
            m_flush = '0;
        end else if (fl) begin
            if (m_flush != CMAX) m_flush = m_flush + 1'b1;
            mq.delete();
        end else begin
            if (ov && !ordy && m_stall != CMAX) m_stall = m_stall + 1'b1;
            if (ov && ordy) void'(mq.pop_front());
            if (iv && ir) mq.push_back('{pc: pc, instr: ins});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, '0, '0, ordy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_model act=%h exp=%h", act_vec(), exp_vec());
        end
        total++;
        if ({out_valid, in_ready, out_instr, out_pc, out_pc_plus4} !== {1'b0, 1'b1, NOP, 16'h0, 16'h0}) begin
            bad++; $display("FAIL reset_outputs valid=%b ready=%b instr=%h pc=%h pc4=%h exp 0 1 %h 0 0",
                            out_valid, in_ready, out_instr, out_pc, out_pc_plus4, NOP);
        end
        total++;
        if ({stall_cnt, flush_cnt} !== 8'h00) begin
            bad++; $display("FAIL reset_counters stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_stream();
        logic [15:0] pcs  [3] = '{16'h0000, 16'h0004, 16'h0008};
        logic [31:0] ins  [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        logic [15:0] pc4s [3] = '{16'h0004, 16'h0008, 16'h000C};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, pcs[i], ins[i], 1'b1);
            total++;
            if ({out_valid, in_ready, out_pc, out_pc_plus4, out_instr, stall_cnt} !==
                {1'b1, 1'b1, pcs[i], pc4s[i], ins[i], 4'd0}) begin
                bad++; $display("FAIL stream_%0d v=%b r=%b pc=%h pc4=%h ins=%h st=%0d exp pc=%h pc4=%h ins=%h",
                                i, out_valid, in_ready, out_pc, out_pc_plus4, out_instr, stall_cnt,
                                pcs[i], pc4s[i], ins[i]);
            end
        end
        idle(1'b1);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL stream_drain act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic fill_two(input logic [15:0] pc0, input logic [15:0] pc1);
        step(1'b0, 1'b0, 1'b1, pc0, 32'hA000_0000 | 32'(pc0), 1'b0);
        step(1'b0, 1'b0, 1'b1, pc1, 32'hA000_0000 | 32'(pc1), 1'b0);
    endtask

    task automatic test_skid();
        logic [CNT_W-1:0] st0;
        st0 = stall_cnt;
        fill_two(16'h0010, 16'h0014);
        total++;
        if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 16'h0010}) begin
            bad++; $display("FAIL skid_full ready=%b valid=%b pc=%h exp 0 1 0010", in_ready, out_valid, out_pc);
        end
        step(1'b0, 1'b0, 1'b1, 16'h0099, 32'hDEAD_BEEF, 1'b0);
        idle(1'b0);
        total++;
        if (stall_cnt !== st0 + 4'd3 || out_pc !== 16'h0010) begin
            bad++; $display("FAIL skid_hold stall=%0d pc=%h exp %0d 0010", stall_cnt, out_pc, st0 + 4'd3);
        end
        idle(1'b1);
        total++;
        if ({out_valid, out_pc, out_pc_plus4, in_ready} !== {1'b1, 16'h0014, 16'h0018, 1'b1}) begin
            bad++; $display("FAIL skid_release_second v=%b pc=%h pc4=%h r=%b exp 1 0014 0018 1",
                            out_valid, out_pc, out_pc_plus4, in_ready);
        end
        idle(1'b1);
        total++;
        if (out_valid !== 1'b0 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL skid_release_empty act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_flush_two();
        fill_two(16'h0010, 16'h0014);
        step(1'b0, 1'b1, 1'b1, 16'h0018, 32'h0000_0F18, 1'b0);
        total++;
        if ({out_valid, out_instr, in_ready, out_pc} !== {1'b0, 32'h0000_0013, 1'b1, 16'h0}) begin
            bad++; $display("FAIL flush_two v=%b ins=%h r=%b pc=%h exp 0 00000013 1 0000",
                            out_valid, out_instr, in_ready, out_pc);
        end
        total++;
        if (flush_cnt !== m_flush || m_flush !== 4'd1) begin
            bad++; $display("FAIL flush_count act=%0d exp=%0d", flush_cnt, m_flush);
        end
        idle(1'b1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_no_leak v=%b pc=%h exp v=0", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 16'hFFFC, 32'h1234_5678, 1'b1);
        total++;
        if ({out_pc, out_pc_plus4} !== {16'hFFFC, 16'h0000}) begin
            bad++; $display("FAIL wrap pc=%h pc4=%h exp fffc 0000", out_pc, out_pc_plus4);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        fill_two(16'h0200, 16'h0204);
        step(1'b1, 1'b1, 1'b1, 16'h0208, 32'h0, 1'b0);
        total++;
        if ({out_valid, in_ready, stall_cnt, flush_cnt} !== {1'b1 ^ 1'b1, 1'b1, 4'd0, 4'd0}) begin
            bad++; $display("FAIL reset_mid v=%b r=%b st=%0d fl=%0d exp 0 1 0 0",
                            out_valid, in_ready, stall_cnt, flush_cnt);
        end
        idle(1'b1);
        idle(1'b1);
        total++;
        if (out_valid !== 1'b0 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_mid_stale act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0300, 32'h0000_0300, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        total++;
        if (stall_cnt !== 4'd15 || out_pc !== 16'h0300) begin
            bad++; $display("FAIL stall_saturate stall=%0d pc=%h exp 15 0300", stall_cnt, out_pc);
        end
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        total++;
        if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin
            bad++; $display("FAIL flush_saturate flush=%0d stall=%0d exp 15 15", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 PC_W'($urandom), $urandom, $urandom_range(0, 2) != 0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; errs++;
                if (errs <= 5) $display("FAIL random_%0d act=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_skid();
        test_flush_two();
        test_wrap();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
